shift_frame_ctrl: RTL and testbench

Two-requester controller for the shared serial shift-out datapath. It arbitrates round-robin between two parallel-word sources and loads the winner's word into an internal shift register. It then sequences the register through exactly WIDTH right-shifts, LSB first, with a per-bit strobe and an end-of-frame pulse. It sits between the parallel producers and the single serial output line. A counter, FSM and arbiter replace the free-running SISO shifter.

---
 rtl/shift_frame_ctrl.sv | 164 ++++++++++++++++
 tb/tb_shift_frame_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shift_frame_ctrl.sv
// shift_frame_ctrl
//   Two-requester round-robin front end for the shared serial shift-out line.
//   The winning requester's word is loaded into a shift register and sent
//   LSB first over WIDTH cycles, with so_valid marking each bit and done
//   pulsing on the final bit of the frame.
//
//   Optional feature macro: SHIFT_FRAME_PARITY_EN
//     When defined, an extra frame bit follows the data bits. It carries the
//     even parity (XOR) of the accepted word, and done moves to that bit.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   req0_valid/data     requester 0 word offer (data held until ready)
//   req0_ready          requester 0 accepted this cycle (combinational)
//   req1_valid/data     requester 1 word offer
//   req1_ready          requester 1 accepted this cycle (combinational)
//   so                  serial data out (0 when so_valid is low)
//   so_valid            so carries a frame bit
//   busy                frame in progress
//   done                one-cycle pulse with the last frame bit
//   grant_id            owner of the current or most recent frame
module shift_frame_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             so,
  output logic             so_valid,
  output logic             busy,
  output logic             done,
  output logic             grant_id
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(WIDTH - 2);

`ifdef SHIFT_FRAME_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_last;
  logic             r_grant;
  logic             r_so;
  logic             r_so_valid;
  logic             r_busy;
  logic             r_done;
`ifdef SHIFT_FRAME_PARITY_EN
  logic             r_par;
`endif

  logic             w_any;
  logic             w_win;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  // Round-robin: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    w_any = req0_valid | req1_valid;
    if (req0_valid & req1_valid) begin
      w_win = ~r_last;
    end else begin
      w_win = req1_valid;
    end
  end

  // The winner is always a valid requester, so a grant is also a transfer.
  assign w_xfer     = (r_state == S_IDLE) & ~rst & w_any;
  assign w_data     = w_win ? req1_data : req0_data;
  assign req0_ready = w_xfer & ~w_win;
  assign req1_ready = w_xfer & w_win;

  // Serial outputs are registered one bit ahead: the value loaded into r_so
  // at each edge is the bit the shift register exposes after that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_grant    <= 1'b0;
      r_so       <= 1'b0;
      r_so_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SHIFT_FRAME_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_shreg    <= w_data;
            r_cnt      <= '0;
            r_last     <= w_win;
            r_grant    <= w_win;
            r_state    <= S_SHIFT;
            r_so       <= w_data[0];
            r_so_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
`ifdef SHIFT_FRAME_PARITY_EN
            r_par      <= ^w_data;
`endif
          end
        end
        S_SHIFT: begin
          r_shreg <= r_shreg >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) begin
`ifdef SHIFT_FRAME_PARITY_EN
            r_state    <= S_PAR;
            r_so       <= r_par;
            r_so_valid <= 1'b1;
            r_done     <= 1'b1;
`else
            r_state    <= S_IDLE;
            r_so       <= 1'b0;
            r_so_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`endif
          end else begin
            r_so <= r_shreg[1];
`ifdef SHIFT_FRAME_PARITY_EN
            r_done <= 1'b0;
`else
            r_done <= (r_cnt == PRE_LAST_IDX);
`endif
          end
        end
`ifdef SHIFT_FRAME_PARITY_EN
        S_PAR: begin
          r_state    <= S_IDLE;
          r_so       <= 1'b0;
          r_so_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign so       = r_so;
  assign so_valid = r_so_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Testbench for shift_frame_ctrl: directed scenarios followed by random
// traffic, all checked cycle by cycle against a frame-level reference model.
module tb_shift_frame_ctrl;

  localparam int unsigned W = 8;
`ifdef SHIFT_FRAME_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v0 = 1'b0;
  logic         v1 = 1'b0;
  logic [W-1:0] d0 = '0;
  logic [W-1:0] d1 = '0;
  logic         rdy0, rdy1, so, so_valid, busy, done, grant_id;

  int n_checks = 0;
  int n_errors = 0;

  shift_frame_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v0),
    .req0_data  (d0),
    .req0_ready (rdy0),
    .req1_valid (v1),
    .req1_data  (d1),
    .req1_ready (rdy1),
    .so         (so),
    .so_valid   (so_valid),
    .busy       (busy),
    .done       (done),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is "transfer cycle + word"; every output of a
  // later cycle follows from how many cycles have passed since the transfer.
  int           cyc = 0;
  bit           m_init = 0;
  bit           m_act = 0;
  int           m_t = 0;
  logic [W-1:0] m_word = '0;
  bit           m_last = 1;
  bit           m_grant = 0;
  bit           acc0 = 0;
  bit           acc1 = 0;

  always @(negedge clk) begin
    int  k;
    bit  in_frame, e_so, e_done, win, any, e_r0, e_r1;
    cyc++;
    k        = cyc - m_t;
    in_frame = m_act && (k >= 1) && (k <= FLEN);
    e_so     = 1'b0;
    if (in_frame) begin
      if (k <= W) e_so = m_word[k-1];
      else        e_so = ^m_word;
    end
    e_done = in_frame && (k == FLEN);
    any    = v0 || v1;
    win    = (v0 && v1) ? !m_last : v1;
    e_r0   = !in_frame && !rst && any && !win;
    e_r1   = !in_frame && !rst && any && win;
    if (m_init) begin
      check_eq("so",       so,       e_so);
      check_eq("so_valid", so_valid, in_frame);
      check_eq("busy",     busy,     in_frame);
      check_eq("done",     done,     e_done);
      check_eq("grant_id", grant_id, m_grant);
      check_eq("ready0",   rdy0,     e_r0);
      check_eq("ready1",   rdy1,     e_r1);
    end
    acc0 = 0;
    acc1 = 0;
    if (rst) begin
      m_init  = 1;
      m_act   = 0;
      m_last  = 1;
      m_grant = 0;
    end else if (m_init && (e_r0 || e_r1)) begin
      acc0    = e_r0;
      acc1    = e_r1;
      m_act   = 1;
      m_t     = cyc;
      m_word  = win ? d1 : d0;
      m_last  = win;
      m_grant = win;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int id);
    int n;
    n = 0;
    while (1) begin
      step();
      if ((id == 0) ? acc0 : acc1) break;
      n++;
      if (n > 50) begin
        check_eq("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    if (id == 0) v0 = 1'b0;
    else         v1 = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;

    // Single requester, 8'hA5
    v0 = 1'b1; d0 = 8'hA5;
    wait_acc(0);
    repeat (12) step();

    // Both held continuously: grants alternate
    v0 = 1'b1; d0 = 8'h01;
    v1 = 1'b1; d1 = 8'h80;
    repeat (45) step();
    v0 = 1'b0; v1 = 1'b0;
    repeat (12) step();

    // req1 arrives mid-frame of req0
    v0 = 1'b1; d0 = 8'h3C;
    wait_acc(0);
    repeat (3) step();
    v1 = 1'b1; d1 = 8'hC3;
    wait_acc(1);
    repeat (12) step();

    // Reset while bit 3 of an 8'hFF frame is on the line
    v0 = 1'b1; d0 = 8'hFF;
    wait_acc(0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    v0 = 1'b1; d0 = 8'h5A;
    v1 = 1'b1; d1 = 8'hA5;
    wait_acc(0);
    wait_acc(1);
    repeat (12) step();

    // Parity-relevant words
    v0 = 1'b1; d0 = 8'h07;
    wait_acc(0);
    v1 = 1'b1; d1 = 8'h03;
    wait_acc(1);
    repeat (12) step();

    // Quiet bus
    repeat (20) step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step();
      rst = ($urandom_range(0, 149) == 0);
      if (v0 && acc0) begin
        v0 = ($urandom_range(0, 1) == 1); d0 = W'($urandom);
      end else if (v0) begin
        if ($urandom_range(0, 15) == 0) v0 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        v0 = 1'b1; d0 = W'($urandom);
      end
      if (v1 && acc1) begin
        v1 = ($urandom_range(0, 1) == 1); d1 = W'($urandom);
      end else if (v1) begin
        if ($urandom_range(0, 15) == 0) v1 = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        v1 = 1'b1; d1 = W'($urandom);
      end
    end
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (15) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
